// File: rtl/ball_pkg.sv
// ball_pkg: shared FSM encoding, bounce-mode codes and fixed-point width helpers.
package ball_pkg;
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
    localparam int MODE_RETIRE = 0;
    localparam int MODE_BOUNCE = 1;
    function automatic int fix_w(input int pos_w, input int frac_w);
        return pos_w + frac_w + 1;
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ball_step.sv
// ball_step: combinational one-frame physics step for a single ball slot.
module ball_step import ball_pkg::*; #(
    parameter int PW          = 15,
    parameter int FRAC_W      = 4,
    parameter int GRAVITY     = 3,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_R      = 4,
    parameter int BOUNCE_MODE = 1,
    parameter int MIN_BOUNCE  = 8
) (
    input  logic signed [PW-1:0] x,
    input  logic signed [PW-1:0] y,
    input  logic signed [PW-1:0] vx,
    input  logic signed [PW-1:0] vy,
    output logic signed [PW-1:0] nx,
    output logic signed [PW-1:0] ny,
    output logic signed [PW-1:0] nvy,
    output logic                 alive
);
    localparam logic signed [PW-1:0] FLOOR = PW'((SCREEN_H - 1 - BALL_R) << FRAC_W);
    localparam logic signed [PW-1:0] X_END = PW'(SCREEN_W << FRAC_W);
    localparam logic signed [PW-1:0] MINB  = PW'(MIN_BOUNCE);
    localparam logic signed [PW-1:0] GRAV  = PW'(GRAVITY);
    logic signed [PW-1:0] sx, sy, mag, bvy;
    logic hit, gone;
    always_comb begin
        sx    = x + vx;
        sy    = y - vy;
        mag   = vy[PW-1] ? -vy : vy;
        bvy   = mag - (mag >>> 2);
        gone  = sx[PW-1] || sx >= X_END;
        hit   = sy >= FLOOR;
        nx    = sx;
        ny    = hit ? FLOOR : sy;
        nvy   = hit ? bvy : vy - GRAV;
        // a floor hit survives only as a bounce strong enough to leave the floor
        alive = !gone && !(hit && (BOUNCE_MODE == MODE_RETIRE || bvy < MINB));
    end
endmodule

// File: rtl/projectile_engine.sv
// projectile_engine: multi-slot ballistic ball engine with a time-shared physics step
// and a registered raster hit output for VGA overlay.
module projectile_engine import ball_pkg::*; #(
    parameter int NUM_BALLS   = 4,
    parameter int POS_W       = 10,
    parameter int FRAC_W      = 4,
    parameter int VEL_W       = 10,
    parameter int GRAVITY     = 3,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_R      = 4,
    parameter int BOUNCE_MODE = 1,
    parameter int MIN_BOUNCE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 update,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [POS_W-1:0]     launch_x,
    input  logic [POS_W-1:0]     launch_y,
    input  logic [VEL_W-1:0]     launch_vx,
    input  logic [VEL_W-1:0]     launch_vy,
    input  logic [POS_W-1:0]     xCount,
    input  logic [POS_W-1:0]     yCount,
    output logic                 ball_pixel,
    output logic [NUM_BALLS-1:0] active_mask,
    output logic                 busy
);
    localparam int PW = fix_w(POS_W, FRAC_W);
    localparam int IW = idx_w(NUM_BALLS);
    localparam logic [IW-1:0] LAST = IW'(NUM_BALLS - 1);
    localparam logic signed [PW:0] R = (PW+1)'(BALL_R);

    state_t state, state_n;
    logic pending, free;
    logic [IW-1:0] idx, free_idx;
    logic [NUM_BALLS-1:0] active, near;
    logic signed [PW-1:0] px [NUM_BALLS];
    logic signed [PW-1:0] py [NUM_BALLS];
    logic signed [PW-1:0] pvx [NUM_BALLS];
    logic signed [PW-1:0] pvy [NUM_BALLS];
    logic signed [PW-1:0] nx, ny, nvy;
    logic alive;

    ball_step #(
        .PW(PW), .FRAC_W(FRAC_W), .GRAVITY(GRAVITY), .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H), .BALL_R(BALL_R), .BOUNCE_MODE(BOUNCE_MODE), .MIN_BOUNCE(MIN_BOUNCE)
    ) u_step (
        .x(px[idx]), .y(py[idx]), .vx(pvx[idx]), .vy(pvy[idx]),
        .nx(nx), .ny(ny), .nvy(nvy), .alive(alive)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? ((update || pending) ? SWEEP : IDLE) : (idx == LAST ? IDLE : SWEEP);
    end

    always_comb begin
        busy         = state == SWEEP;
        launch_ready = state == IDLE && !pending && !update && free;
        active_mask  = active;
    end

    always_comb begin
        free     = ~&active;
        free_idx = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (!active[i]) free_idx = IW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            idx     <= '0;
            active  <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                px[i]  <= '0;
                py[i]  <= '0;
                pvx[i] <= '0;
                pvy[i] <= '0;
            end
        end else begin
            if (state == IDLE) begin
                pending <= 1'b0;
                idx     <= '0;
            end else begin
                pending <= pending || update;
                idx     <= idx + 1'b1;
                if (active[idx]) begin
                    px[idx]     <= nx;
                    py[idx]     <= ny;
                    pvy[idx]    <= nvy;
                    active[idx] <= alive;
                end
            end
            if (launch_valid && launch_ready) begin
                px[free_idx]     <= {1'b0, launch_x, {FRAC_W{1'b0}}};
                py[free_idx]     <= {1'b0, launch_y, {FRAC_W{1'b0}}};
                pvx[free_idx]    <= {{(PW-VEL_W){launch_vx[VEL_W-1]}}, launch_vx};
                pvy[free_idx]    <= {{(PW-VEL_W){launch_vy[VEL_W-1]}}, launch_vy};
                active[free_idx] <= 1'b1;
            end
        end
    end

    // distances use integer pixel parts; balls above the screen (y < 0) are never drawn
    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_near
        logic signed [PW:0] dx, dy;
        assign dx = $signed({{(FRAC_W+1){1'b0}}, xCount}) - (PW+1)'(px[g] >>> FRAC_W);
        assign dy = $signed({{(FRAC_W+1){1'b0}}, yCount}) - (PW+1)'(py[g] >>> FRAC_W);
        assign near[g] = active[g] && !py[g][PW-1] && dx >= -R && dx <= R && dy >= -R && dy <= R;
    end

    always_ff @(posedge clk) begin
        if (rst) ball_pixel <= 1'b0;
        else     ball_pixel <= |near;
    end
endmodule

// File: tb/tb_projectile_engine.sv
// tb_projectile_engine: directed and randomized checks against an integer reference model.
module tb_projectile_engine;
    localparam int N = 4;
    localparam int FLOOR = (480 - 1 - 4) * 16;

    logic clk = 0, rst = 1, update = 0, launch_valid = 0;
    logic launch_ready, ball_pixel, busy;
    logic [9:0] launch_x = 0, launch_y = 0, launch_vx = 0, launch_vy = 0, xCount = 0, yCount = 0;
    logic [N-1:0] active_mask;

    int n_cmp = 0, n_err = 0;
    int mx[N], my[N], mvx[N], mvy[N];
    bit ma[N];

    projectile_engine dut (
        .clk(clk), .rst(rst), .update(update), .launch_valid(launch_valid),
        .launch_ready(launch_ready), .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy), .xCount(xCount), .yCount(yCount),
        .ball_pixel(ball_pixel), .active_mask(active_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; ma[i] = 0;
        end
    endtask

    task automatic model_launch(input int x, input int y, input int vx, input int vy);
        for (int i = 0; i < N; i++)
            if (!ma[i]) begin
                mx[i] = x * 16; my[i] = y * 16; mvx[i] = vx; mvy[i] = vy; ma[i] = 1;
                return;
            end
    endtask

    // one frame of physics in plain fraction-unit integers
    task automatic model_frame();
        int nx, ny, b;
        for (int i = 0; i < N; i++) begin
            if (!ma[i]) continue;
            nx = mx[i] + mvx[i];
            ny = my[i] - mvy[i];
            mx[i] = nx;
            if (nx < 0 || nx / 16 > 639) ma[i] = 0;
            if (ny >= FLOOR) begin
                b = iabs(mvy[i]) - iabs(mvy[i]) / 4;
                my[i] = FLOOR;
                mvy[i] = b;
                if (b < 8) ma[i] = 0;
            end else begin
                my[i] = ny;
                mvy[i] = mvy[i] - 3;
            end
        end
    endtask

    function automatic logic model_pixel(input int xc, input int yc);
        for (int i = 0; i < N; i++)
            if (ma[i] && my[i] >= 0 && iabs(xc - mx[i] / 16) <= 4 && iabs(yc - my[i] / 16) <= 4)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = ma[i];
        return m;
    endfunction

    task automatic check_slots(input string tag);
        check({tag, "_mask"}, active_mask, model_mask());
        for (int i = 0; i < N; i++)
            if (ma[i]) begin
                check($sformatf("%s_x%0d", tag, i), dut.px[i], mx[i]);
                check($sformatf("%s_y%0d", tag, i), dut.py[i], my[i]);
                check($sformatf("%s_vy%0d", tag, i), dut.pvy[i], mvy[i]);
            end
    endtask

    task automatic do_reset();
        rst = 1; update = 0; launch_valid = 0;
        tick(); tick();
        rst = 0;
        model_reset();
    endtask

    task automatic do_launch(input int x, input int y, input int vx, input int vy);
        int w = 0;
        launch_x = 10'(x); launch_y = 10'(y); launch_vx = 10'(vx); launch_vy = 10'(vy);
        launch_valid = 1;
        while (!launch_ready && w < 100) begin tick(); w++; end
        if (w >= 100) begin
            n_cmp++; n_err++;
            $error("FAIL launch_wait: observed no ready within 100 cycles");
        end
        tick();
        launch_valid = 0;
        model_launch(x, y, vx, vy);
    endtask

    task automatic do_update(output int nb);
        update = 1;
        tick();
        update = 0;
        nb = 0;
        while (busy && nb < 50) begin nb++; tick(); end
        model_frame();
    endtask

    task automatic probe(input string tag, input int xc, input int yc);
        xCount = 10'(xc < 0 ? 0 : xc);
        yCount = 10'(yc < 0 ? 0 : yc);
        tick();
        check(tag, ball_pixel, model_pixel(int'(xCount), int'(yCount)));
    endtask

    initial begin
        int nb, s, xc, yc;
        do_reset();
        rst = 1; tick();
        check("rst_ready", launch_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pixel", ball_pixel, 0);
        check("rst_mask", active_mask, 0);
        rst = 0;

        do_launch(100, 400, 16, 32);
        check("l0_mask", active_mask, 4'b0001);
        check("l0_ready", launch_ready, 1);
        check("l0_busy", busy, 0);

        do_update(nb);
        check("u0_busy_cycles", nb, 4);
        check("u0_x", dut.px[0], 101 * 16);
        check("u0_y", dut.py[0], 398 * 16);
        check("u0_vy", dut.pvy[0], 29);
        check_slots("u0");

        do_launch(637, 200, 100, 0);
        do_launch(300, 300, 2, 4);
        do_launch(400, 250, -3, 10);
        check("full_mask", active_mask, 4'b1111);
        check("full_ready", launch_ready, 0);
        launch_x = 10'd320; launch_y = 10'd100; launch_vx = 10'd5; launch_vy = 10'd5;
        launch_valid = 1;
        tick();
        check("held_ready", launch_ready, 0);
        do_update(nb);
        check("held_retire_mask", active_mask, 4'b1101);
        do_launch(320, 100, 5, 5);
        check("held_into_slot1", dut.px[1], 320 * 16);
        check_slots("held");

        do_reset();
        do_launch(300, 475, 0, -40);
        do_launch(320, 475, 0, -8);
        do_update(nb);
        check("bounce_y", dut.py[0], 475 * 16);
        check("bounce_vy", dut.pvy[0], 30);
        check("bounce_retire_mask", active_mask, 4'b0001);
        check_slots("bounce");

        do_reset();
        do_launch(100, 100, 8, 0);
        update = 1;
        tick(); nb = int'(busy);
        tick(); nb += int'(busy);
        tick(); nb += int'(busy);
        update = 0;
        repeat (12) begin tick(); nb += int'(busy); end
        check("pending_busy_cycles", nb, 8);
        model_frame(); model_frame();
        check_slots("pending");
        launch_x = 10'd50; launch_y = 10'd60; launch_vx = 10'd1; launch_vy = 10'd2;
        launch_valid = 1; update = 1;
        #1;
        check("upd_launch_ready", launch_ready, 0);
        tick();
        update = 0;
        check("upd_launch_mask", active_mask, 4'b0001);
        s = 0;
        while (busy && s < 50) begin tick(); s++; end
        model_frame();
        do_launch(50, 60, 1, 2);
        check_slots("upd_launch");

        do_reset();
        do_launch(200, 300, 0, 0);
        probe("pix_inside", 204, 296);
        check("pix_inside_const", ball_pixel, 1);
        probe("pix_outside", 205, 300);
        check("pix_outside_const", ball_pixel, 0);

        update = 1; tick(); update = 0; tick();
        rst = 1; tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", launch_ready, 1);
        check("mid_rst_pixel", ball_pixel, 0);
        check("mid_rst_mask", active_mask, 0);
        check("mid_rst_x0", dut.px[0], 0);
        rst = 0;
        model_reset();

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0 && model_mask() != 4'hf)
                do_launch($urandom_range(50, 590), $urandom_range(50, 450),
                          int'($urandom_range(0, 64)) - 32, int'($urandom_range(0, 128)) - 64);
            else
                do_update(nb);
            check_slots($sformatf("rnd%0d", k));
            s = $urandom_range(0, N - 1);
            xc = mx[s] / 16 + int'($urandom_range(0, 12)) - 6;
            yc = my[s] / 16 + int'($urandom_range(0, 12)) - 6;
            probe($sformatf("rnd_pix%0d", k), xc, yc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/projectile_engine.md
PROJECTILE_ENGINE -- requirements
Module: projectile_engine

Interface
REQ-001 Parameter NUM_BALLS, default 4, number of independent ball slots (1..8).
REQ-002 Parameter POS_W, default 10, integer pixel-coordinate width.
REQ-003 Parameter FRAC_W, default 4, fractional bits of position and velocity.
REQ-004 Parameter VEL_W, default 10, signed velocity width including fraction bits.
REQ-005 Parameter GRAVITY, default 3, per-frame vy decrement in fraction units.
REQ-006 Parameter SCREEN_W / SCREEN_H, default 640 / 480, visible area in pixels.
REQ-007 Parameter BALL_R, default 4, half-size of the drawn square ball in pixels.
REQ-008 Parameter BOUNCE_MODE, default 1: 0 = ball retires on floor contact; 1 = damped bounce.
REQ-009 Parameter MIN_BOUNCE, default 8, fraction-unit |vy| below which a bounce retires the ball.
REQ-010 clk  in  1  single clock (VGA pixel clock domain); all logic on rising edge.
REQ-011 rst  in  1  reset, synchronous, active-high.
REQ-012 update  in  1  one-cycle frame-advance strobe.
REQ-013 launch_valid  in  1  launch request; launch_ready  out  1  a free slot is available and the engine is idle.
REQ-014 launch_x, launch_y  in  POS_W  start pixel; launch_vx, launch_vy  in  VEL_W  signed start velocity (vy positive = upward).
REQ-015 xCount, yCount  in  POS_W  current raster pixel.
REQ-016 ball_pixel  out  1  raster pixel lies inside any active ball.
REQ-017 active_mask  out  NUM_BALLS  per-slot in-flight flags; busy  out  1  physics sweep in progress.

Function
REQ-018 Engine FSM states: IDLE, SWEEP; IDLE->SWEEP on update (or on pending update), SWEEP->IDLE after the slot NUM_BALLS-1 step.
REQ-019 SWEEP processes one slot per cycle, index 0 first; busy is high exactly NUM_BALLS cycles per frame.
REQ-020 An update arriving during SWEEP sets a single pending flag; further updates while pending are dropped; pending starts the next SWEEP immediately on return to IDLE.
REQ-021 launch_ready = IDLE, no pending update, no update this cycle, and at least one slot inactive.
REQ-022 A launch transfers when launch_valid and launch_ready are both high; it loads the lowest-index inactive slot with the position (fraction bits zero) and velocity, and sets its active bit next cycle.
REQ-023 Update takes priority over launch in the same cycle; the launch is held off (ready low), not lost, if valid is held.
REQ-024 Per active slot step: x += vx; y -= vy; vy -= GRAVITY; all in signed (POS_W+FRAC_W+1)-bit arithmetic, no wrap.
REQ-025 New x < 0 or x > SCREEN_W-1 retires the slot (active cleared); y < 0 is allowed (ball off-screen top, not drawn).
REQ-026 Floor contact when new y >= SCREEN_H-1-BALL_R: mode 0 retires; mode 1 clamps y to the floor and sets vy = |vy| - (|vy| >> 2) (upward, 3/4 speed).
REQ-027 In mode 1, if the post-bounce vy < MIN_BOUNCE the slot retires in that same step.
REQ-028 Inactive slots are skipped (state unchanged) but still consume their SWEEP cycle.
REQ-029 ball_pixel is registered, one cycle after xCount/yCount: high when some active slot has |xCount-x| <= BALL_R and |yCount-y| <= BALL_R (integer parts, y >= 0).
REQ-030 ball_pixel is computed from committed slot state; a slot being written in SWEEP shows its pre- or post-step value, never a mix.

Reset
REQ-031 rst clears FSM to IDLE, pending, all slot positions, velocities and active bits to 0.
REQ-032 After rst: launch_ready = 1 (when NUM_BALLS >= 1), busy = 0, ball_pixel = 0, active_mask = 0.
REQ-033 rst asserted mid-SWEEP aborts the sweep; no partial slot update survives.

Structure
REQ-034 Fixed-point width helpers, FSM state encoding and BOUNCE_MODE codes live in a shared package ball_pkg.
REQ-035 One sub-module, ball_step, holds the combinational per-slot physics (REQ-024..027), instantiated once and time-shared across slots.

Verification
REQ-036 Reset then launch (x=100,y=400,vx=16,vy=32) -> slot 0 active, ready stays 1, busy 0.
REQ-037 One update after REQ-036 -> busy high 4 cycles; slot 0 at x=101, y=398, vy=29 (fraction units).
REQ-038 Fill all 4 slots -> launch_ready 0; fifth launch_valid held until a slot retires, then accepted into that slot.
REQ-039 Mode 1, slot falling with vy=-40 crossing floor -> y=475, vy=30; vy=-8 crossing floor -> vy=6 < 8, slot retires.
REQ-040 update pulses 1 and 2 cycles into SWEEP -> exactly one extra SWEEP follows; launch in same cycle as update -> not accepted that cycle.
REQ-041 Ball at (200,300), raster (204,296) -> ball_pixel 1 one cycle later; raster (205,300) -> 0; rst mid-SWEEP -> all outputs at reset values next cycle.
